video_timing_gen: RTL
=====================

Name: video_timing_gen

Overview:
- Generates the raster timing that feeds hdmi_top: horizontal and vertical counters, hsync, vsync, data-enable and active-pixel coordinates, all in the pixel clock domain.
- Its outputs drive the Tetris pixel renderer and the TMDS encoders inside hdmi_top.
- Default timing is 640x480 at 60 Hz (800x525 total); all totals are parameterised.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- CW, 10, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- pixclk  in  1  pixel clock (25 MHz default); the only clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  advance enable; the raster moves one pixel per pixclk edge with en=1
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- de  out  1  high during active video
- x  out  CW  active column 0..H_ACTIVE-1; 0 when de=0
- y  out  CW  active row 0..V_ACTIVE-1; 0 when de=0
- line_start  out  1  one-cycle pulse on entering h=0
- frame_start  out  1  one-cycle pulse on entering h=0, v=0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is the vertical equivalent.
- Internal counters: h in 0..H_TOTAL-1, v in 0..V_TOTAL-1.
- Reset (async, rst_n=0):
  - h=H_TOTAL-1, v=V_TOTAL-1
  - de=0, x=0, y=0, line_start=0, frame_start=0
  - hsync=~HS_POL, vsync=~VS_POL
- All outputs are registers updated on the same edge as the counters, computed from the next counter value. They are therefore always aligned to the current (h,v); there is no extra latency.
- Advance (en=1):
  - h wraps H_TOTAL-1 -> 0.
  - On the h wrap, v increments; v wraps V_TOTAL-1 -> 0.
- Stall (en=0): h, v, de, x, y, hsync and vsync hold; line_start and frame_start drive 0.
- Pulses: line_start=1 only on an enabled edge where h becomes 0. frame_start=1 only on an enabled edge where h and v both become 0.
- Data enable: de=1 iff h<H_ACTIVE and v<V_ACTIVE. When de=1, x=h and y=v.
- hsync is active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
- vsync is active iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. vsync changes on the h wrap edge only, i.e. it is line-aligned.
- First enabled edge after reset release: h=0, v=0, de=1, x=0, y=0, line_start=1, frame_start=1.
- Reset asserted mid-frame: immediate return to the reset state. No partial-frame recovery.
- Counter arithmetic is unsigned CW-bit. Comparisons use constant localparams; no multipliers.

Optional Feature:
- Macro: VIDEO_TIMING_GEN_TEST_PATTERN_EN
- With the macro defined:
  - Extra output rgb, out, 24 bits, registered and aligned with de.
  - Eight vertical colour bars, bar index = x / (H_ACTIVE/8), implemented by comparison with constant boundaries.
  - Colours in order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - rgb=0 whenever de=0, during a stall with de=0, and at reset.
- Without the macro: the rgb port and its logic are absent.

Test Plan:
- Release reset with en=1 -> first edge gives x=0, y=0, de=1, line_start=1, frame_start=1; next edge gives x=1, line_start=0.
- Free-run with en=1 -> frame_start period is exactly 420000 cycles and line_start period is 800 cycles.
  - de high for exactly 640 cycles per active line and 480 lines per frame.
  - hsync low for h=656..751; vsync low for v=490..491.
- Drive en=0 for 37 cycles at h=639, v=100 -> x=639, y=100, de=1 held throughout, no pulses; resuming en=1 gives de=0 at h=640.
- Assert rst_n=0 asynchronously at h=300, v=200 -> outputs reach reset values before the next pixclk edge; after release, the first enabled edge gives frame_start=1 with x=0, y=0.
- Run the boundary at h=799, v=524 -> next edge wraps to h=0, v=0, frame_start=1; no cycle is seen with v=525 or h=800.
- With VIDEO_TIMING_GEN_TEST_PATTERN_EN defined:
  - x=79 -> rgb=FFFFFF; x=80 -> FFFF00; x=639 -> 000000.
  - h=640 (de=0) -> rgb=000000.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, syncs, data-enable and pixel coordinates.
// Define VIDEO_TIMING_GEN_TEST_PATTERN_EN to add the 24-bit colour-bar rgb output.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10
) (
  input  logic          pixclk,
  input  logic          rst_n,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
  ,
  output logic [23:0]   rgb
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_S   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_E   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_S   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_E   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
    end
  end

  // Outputs derive from the next counter value so they line up with (h,v).
  always_comb begin
    de_d = (h_d < H_ACT) && (v_d < V_ACT);
    x_d  = de_d ? h_d : '0;
    y_d  = de_d ? v_d : '0;
    hs_d = ((h_d >= HS_S) && (h_d < HS_E)) ? HS_POL : ~HS_POL;
    vs_d = ((v_d >= VS_S) && (v_d < VS_E)) ? VS_POL : ~VS_POL;
    ls_d = en && (h_d == '0);
    fs_d = en && (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      h_q  <= H_LAST;
      v_q  <= V_LAST;
      x_q  <= '0;
      y_q  <= '0;
      de_q <= 1'b0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      x_q  <= x_d;
      y_q  <= y_d;
      de_q <= de_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
  localparam int BAR = H_ACTIVE / 8;
  localparam logic [CW-1:0] B1 = CW'(BAR * 1);
  localparam logic [CW-1:0] B2 = CW'(BAR * 2);
  localparam logic [CW-1:0] B3 = CW'(BAR * 3);
  localparam logic [CW-1:0] B4 = CW'(BAR * 4);
  localparam logic [CW-1:0] B5 = CW'(BAR * 5);
  localparam logic [CW-1:0] B6 = CW'(BAR * 6);
  localparam logic [CW-1:0] B7 = CW'(BAR * 7);

  logic [23:0] rgb_q, rgb_d;

  always_comb begin
    rgb_d = 24'h000000;
    if (de_d) begin
      if      (x_d < B1) rgb_d = 24'hFFFFFF;
      else if (x_d < B2) rgb_d = 24'hFFFF00;
      else if (x_d < B3) rgb_d = 24'h00FFFF;
      else if (x_d < B4) rgb_d = 24'h00FF00;
      else if (x_d < B5) rgb_d = 24'hFF00FF;
      else if (x_d < B6) rgb_d = 24'hFF0000;
      else if (x_d < B7) rgb_d = 24'h0000FF;
      else               rgb_d = 24'h000000;
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) rgb_q <= '0;
    else        rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;
`endif

endmodule
